// File: rtl/biu_sequencer_pkg.sv
// Shared definitions for the bus interface unit sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package biu_sequencer_pkg;

    // Bus-cycle sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Segment selector codes presented to the address generator.
    typedef enum logic [1:0] {
        SEG_CS = 2'd0,
        SEG_DS = 2'd1,
        SEG_ES = 2'd2,
        SEG_SS = 2'd3
    } seg_e;

    // Base/index register selector codes; REG_NONE drops the term.
    typedef enum logic [2:0] {
        REG_BX   = 3'd0,
        REG_SI   = 3'd1,
        REG_DI   = 3'd2,
        REG_BP   = 3'd3,
        REG_SP   = 3'd4,
        REG_NONE = 3'd5
    } reg_e;

endpackage

// File: rtl/biu_sequencer_prefetch_queue.sv
// Circular prefetch FIFO of 16-bit instruction words with synchronous flush.
// Latency: a pushed word is visible on dat_o the cycle after the push edge.
// Backpressure: none internally; the producer must not push when full, pops on empty are ignored.
//
// Ports: clk_i/rst_n_i clock and synchronous active-low reset; flush_i empties
// the queue (wins over push/pop); push_i/push_dat_i write the tail; pop_i drops
// the head; vld_o = non-empty, dat_o = head word, count_o = occupancy.
module biu_sequencer_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [15:0]   push_dat_i,
    input  logic          pop_i,
    output logic          vld_o,
    output logic [15:0]   dat_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign vld_o   = (count_q != '0);
    assign dat_o   = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/biu_sequencer.sv
// Bus interface unit sequencer: arbitrates EU data accesses against instruction
// prefetch, runs one IDLE/ADDR/WAIT/DONE bus cycle at a time, feeds the prefetch queue.
// Latency: data ack in the 3rd cycle after the grant cycle with zero wait states;
// backpressure via MEM_READY (WAIT repeats), DATA_REQ held until DATA_ACK, prefetch stalls when queue is full.
//
// Ports: clk_i/rst_n_i; data_* EU access request/ack; flush_i/new_ip_i branch
// redirect; q_* prefetch queue head; op/seg/m1/m2/desp/ip address-generator
// controls; mem_* bus cycle request and memory response.
module biu_sequencer
    import biu_sequencer_pkg::*;
#(
    parameter int          QDEPTH   = 4,
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_seg_i,
    input  logic [2:0]  data_m1_i,
    input  logic [2:0]  data_m2_i,
    input  logic [15:0] data_desp_i,
    input  logic [15:0] data_wdata_i,
    output logic        data_ack_o,
    output logic [15:0] data_rdata_o,
    input  logic        flush_i,
    input  logic [15:0] new_ip_i,
    input  logic        q_pop_i,
    output logic        q_valid_o,
    output logic [15:0] q_data_o,
    output logic        op_o,
    output logic [1:0]  seg_sel_o,
    output logic [2:0]  m1_sel_o,
    output logic [2:0]  m2_sel_o,
    output logic [15:0] desp_o,
    output logic [15:0] ip_o,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int CW = $clog2(QDEPTH + 1);

    state_e        state_q,   state_d;
    logic          op_q,      op_d;
    logic          wr_q,      wr_d;
    logic [1:0]    seg_q,     seg_d;
    logic [2:0]    m1_q,      m1_d;
    logic [2:0]    m2_q,      m2_d;
    logic [15:0]   desp_q,    desp_d;
    logic [15:0]   wdata_q,   wdata_d;
    logic [15:0]   rdata_q,   rdata_d;
    logic [15:0]   ip_q,      ip_d;
    logic          discard_q, discard_d;
    logic          push;
    logic [CW-1:0] q_count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            op_q      <= 1'b0;
            wr_q      <= 1'b0;
            seg_q     <= SEG_CS;
            m1_q      <= REG_NONE;
            m2_q      <= REG_NONE;
            desp_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ip_q      <= RESET_IP;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wr_q      <= wr_d;
            seg_q     <= seg_d;
            m1_q      <= m1_d;
            m2_q      <= m2_d;
            desp_q    <= desp_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ip_q      <= ip_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wr_d      = wr_q;
        seg_d     = seg_q;
        m1_d      = m1_q;
        m2_d      = m2_q;
        desp_d    = desp_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ip_d      = ip_q;
        discard_d = discard_q;

        unique case (state_q)
            ST_IDLE: begin
                // Controls are latched only here so they stay frozen for the
                // whole bus cycle regardless of what the EU does meanwhile.
                if (data_req_i) begin
                    state_d   = ST_ADDR;
                    op_d      = 1'b1;
                    wr_d      = data_wr_i;
                    seg_d     = data_seg_i;
                    m1_d      = data_m1_i;
                    m2_d      = data_m2_i;
                    desp_d    = data_desp_i;
                    wdata_d   = data_wdata_i;
                    discard_d = 1'b0;
                end else if ((q_count < CW'(QDEPTH)) && !flush_i) begin
                    state_d   = ST_ADDR;
                    op_d      = 1'b0;
                    wr_d      = 1'b0;
                    seg_d     = SEG_CS;
                    m1_d      = REG_NONE;
                    m2_d      = REG_NONE;
                    desp_d    = '0;
                    discard_d = 1'b0;
                end
            end
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_ready_i) begin
                    state_d = ST_DONE;
                    rdata_d = mem_rdata_i;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A redirect during a prefetch lets the bus cycle finish but marks its
        // word stale so it is neither queued nor advances the fetch pointer.
        if (flush_i && (state_q != ST_IDLE) && !op_q) begin
            discard_d = 1'b1;
        end

        if (flush_i) begin
            ip_d = new_ip_i;
        end else if (push) begin
            ip_d = ip_q + 16'd2;
        end
    end

    assign push = (state_q == ST_DONE) && !op_q && !discard_q && !flush_i;

    biu_sequencer_prefetch_queue #(
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_queue (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .push_i     (push),
        .push_dat_i (rdata_q),
        .pop_i      (q_pop_i),
        .vld_o      (q_valid_o),
        .dat_o      (q_data_o),
        .count_o    (q_count)
    );

    assign mem_req_o    = (state_q == ST_ADDR) || (state_q == ST_WAIT);
    assign mem_wr_o     = mem_req_o && wr_q;
    assign mem_wdata_o  = wdata_q;
    assign data_ack_o   = (state_q == ST_DONE) && op_q;
    assign data_rdata_o = rdata_q;
    assign op_o         = op_q;
    assign seg_sel_o    = seg_q;
    assign m1_sel_o     = m1_q;
    assign m2_sel_o     = m2_q;
    assign desp_o       = desp_q;
    assign ip_o         = ip_q;

endmodule

// File: tb/tb_biu_sequencer.sv
module tb_biu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req, data_wr;
    logic [1:0]  data_seg;
    logic [2:0]  data_m1, data_m2;
    logic [15:0] data_desp, data_wdata;
    logic        data_ack;
    logic [15:0] data_rdata;
    logic        flush;
    logic [15:0] new_ip;
    logic        q_pop, q_valid;
    logic [15:0] q_data;
    logic        op;
    logic [1:0]  seg_sel;
    logic [2:0]  m1_sel, m2_sel;
    logic [15:0] desp, ip;
    logic        mem_req, mem_wr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ready;

    logic        use_fixed;
    logic [15:0] fixed_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory returns a fixed word or an address-tagged word (0x5000 + fetch pointer).
    assign mem_rdata = use_fixed ? fixed_rdata : 16'h5000 + ip;

    biu_sequencer dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .data_req_i   (data_req),
        .data_wr_i    (data_wr),
        .data_seg_i   (data_seg),
        .data_m1_i    (data_m1),
        .data_m2_i    (data_m2),
        .data_desp_i  (data_desp),
        .data_wdata_i (data_wdata),
        .data_ack_o   (data_ack),
        .data_rdata_o (data_rdata),
        .flush_i      (flush),
        .new_ip_i     (new_ip),
        .q_pop_i      (q_pop),
        .q_valid_o    (q_valid),
        .q_data_o     (q_data),
        .op_o         (op),
        .seg_sel_o    (seg_sel),
        .m1_sel_o     (m1_sel),
        .m2_sel_o     (m2_sel),
        .desp_o       (desp),
        .ip_o         (ip),
        .mem_req_o    (mem_req),
        .mem_wr_o     (mem_wr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ready_i  (mem_ready)
    );

    task automatic test_reset;
        rst_n = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_seg = 2'd0;
        data_m1 = 3'd5; data_m2 = 3'd5; data_desp = 16'h0; data_wdata = 16'h0;
        flush = 1'b0; new_ip = 16'h0; q_pop = 1'b0; mem_ready = 1'b1;
        use_fixed = 1'b0; fixed_rdata = 16'h0;
        repeat (3) @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rst_mem_wr got=%b want=0", mem_wr); end
        total++; if (data_ack !== 1'b0) begin bad++; $display("FAIL rst_data_ack got=%b want=0", data_ack); end
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL rst_q_valid got=%b want=0", q_valid); end
        total++; if (ip !== 16'h0000) begin bad++; $display("FAIL rst_ip got=%h want=0000", ip); end
        total++; if (op !== 1'b0 || seg_sel !== 2'd0) begin bad++; $display("FAIL rst_op_seg got=%b/%0d want=0/0", op, seg_sel); end
        total++; if (m1_sel !== 3'd5 || m2_sel !== 3'd5) begin bad++; $display("FAIL rst_msel got=%0d/%0d want=5/5", m1_sel, m2_sel); end
        total++; if (desp !== 16'h0 || data_rdata !== 16'h0 || mem_wdata !== 16'h0) begin
            bad++; $display("FAIL rst_data_regs got desp=%h rdata=%h wdata=%h want 0", desp, data_rdata, mem_wdata);
        end
    endtask

    task automatic test_prefetch_fill;
        logic [15:0] sip[$];
        logic        prev;
        int          late_req;
        prev = 1'b0; late_req = 0;
        rst_n = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (mem_req && !prev) sip.push_back(ip);
            if (c >= 20 && mem_req) late_req++;
            prev = mem_req;
        end
        total++; if (sip.size() !== 4) begin bad++; $display("FAIL fill_cycles got=%0d want=4", sip.size()); end
        for (int i = 0; i < sip.size(); i++) begin
            total++;
            if (sip[i] !== 16'(2 * i)) begin bad++; $display("FAIL fill_ip%0d got=%h want=%h", i, sip[i], 16'(2 * i)); end
        end
        total++; if (late_req !== 0) begin bad++; $display("FAIL fill_stop got=%0d req cycles want=0", late_req); end
        total++; if (ip !== 16'h0008) begin bad++; $display("FAIL fill_ip_end got=%h want=0008", ip); end
        total++; if (q_valid !== 1'b1 || q_data !== 16'h5000) begin
            bad++; $display("FAIL fill_head got=%b/%h want=1/5000", q_valid, q_data);
        end
    endtask

    task automatic test_data_read;
        // Cycle 0 is the grant (IDLE) cycle; ack expected in cycle 3.
        use_fixed = 1'b1; fixed_rdata = 16'hABCD;
        data_req = 1'b1; data_wr = 1'b0; data_seg = 2'd1; data_m1 = 3'd0; data_m2 = 3'd5; data_desp = 16'h0010;
        @(negedge clk);
        total++; if (mem_req !== 1'b1 || op !== 1'b1 || seg_sel !== 2'd1 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL rd_addr got req=%b op=%b seg=%0d wr=%b want 1/1/1/0", mem_req, op, seg_sel, mem_wr);
        end
        total++; if (m1_sel !== 3'd0 || m2_sel !== 3'd5 || desp !== 16'h0010) begin
            bad++; $display("FAIL rd_ctrl got m1=%0d m2=%0d desp=%h want 0/5/0010", m1_sel, m2_sel, desp);
        end
        @(negedge clk);
        total++; if (data_ack !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL rd_wait got ack=%b req=%b want 0/1", data_ack, mem_req); end
        @(negedge clk);
        total++; if (data_ack !== 1'b1 || data_rdata !== 16'hABCD) begin
            bad++; $display("FAIL rd_ack got ack=%b rdata=%h want 1/ABCD", data_ack, data_rdata);
        end
        data_req = 1'b0;
        @(negedge clk);
        total++; if (data_ack !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rd_after got ack=%b req=%b want 0/0", data_ack, mem_req); end
    endtask

    task automatic test_data_write;
        int reqc, badwr, ackc, ack_at;
        reqc = 0; badwr = 0; ackc = 0; ack_at = 0;
        mem_ready = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_seg = 2'd2; data_m1 = 3'd1; data_m2 = 3'd2;
        data_desp = 16'h1234; data_wdata = 16'hBEEF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_req) begin
                reqc++;
                if (!mem_wr || mem_wdata !== 16'hBEEF) badwr++;
            end
            if (data_ack) begin ackc++; ack_at = k; data_req = 1'b0; end
            if (k == 5) mem_ready = 1'b1;
        end
        total++; if (reqc !== 5) begin bad++; $display("FAIL wr_req_len got=%0d want=5", reqc); end
        total++; if (badwr !== 0) begin bad++; $display("FAIL wr_wr_data got=%0d bad cycles want=0", badwr); end
        total++; if (ackc !== 1 || ack_at !== 6) begin bad++; $display("FAIL wr_ack got count=%0d at=%0d want 1 at 6", ackc, ack_at); end
    endtask

    task automatic test_flush;
        bit          seen;
        logic [15:0] first_ip;
        seen = 1'b0; first_ip = 16'h0;
        total++; if (q_data !== 16'h5000) begin bad++; $display("FAIL fl_head0 got=%h want=5000", q_data); end
        q_pop = 1'b1; mem_ready = 1'b0; use_fixed = 1'b1; fixed_rdata = 16'hDEAD;
        @(negedge clk);
        q_pop = 1'b0;
        total++; if (q_data !== 16'h5002) begin bad++; $display("FAIL fl_pop got=%h want=5002", q_data); end
        @(negedge clk);
        total++; if (mem_req !== 1'b1 || op !== 1'b0 || m1_sel !== 3'd5 || m2_sel !== 3'd5 || desp !== 16'h0) begin
            bad++; $display("FAIL fl_pf_ctrl got req=%b op=%b m1=%0d m2=%0d desp=%h want 1/0/5/5/0000", mem_req, op, m1_sel, m2_sel, desp);
        end
        @(negedge clk);
        flush = 1'b1; new_ip = 16'h1230;
        @(negedge clk);
        flush = 1'b0; mem_ready = 1'b1;
        total++; if (q_valid !== 1'b0 || ip !== 16'h1230) begin bad++; $display("FAIL fl_apply got valid=%b ip=%h want 0/1230", q_valid, ip); end
        @(negedge clk);
        fixed_rdata = 16'h4321;
        @(negedge clk);
        total++; if (q_valid !== 1'b0 || ip !== 16'h1230) begin bad++; $display("FAIL fl_discard got valid=%b ip=%h want 0/1230", q_valid, ip); end
        for (int c = 0; c < 12 && !q_valid; c++) begin
            @(negedge clk);
            if (mem_req && !seen) begin seen = 1'b1; first_ip = ip; end
        end
        total++; if (first_ip !== 16'h1230) begin bad++; $display("FAIL fl_next_ip got=%h want=1230", first_ip); end
        total++; if (q_valid !== 1'b1 || q_data !== 16'h4321 || ip !== 16'h1232) begin
            bad++; $display("FAIL fl_new_word got valid=%b data=%h ip=%h want 1/4321/1232", q_valid, q_data, ip);
        end
    endtask

    task automatic test_wrap_pushpop;
        bit hi;
        hi = 1'b0;
        use_fixed = 1'b0; mem_ready = 1'b1;
        flush = 1'b1; new_ip = 16'hFFFE;
        @(negedge clk);
        flush = 1'b0;
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL wrap_flush got valid=%b want 0", q_valid); end
        for (int c = 0; c < 16 && !q_valid; c++) @(negedge clk);
        total++; if (q_valid !== 1'b1 || q_data !== 16'h4FFE || ip !== 16'h0000) begin
            bad++; $display("FAIL wrap_ip got valid=%b data=%h ip=%h want 1/4FFE/0000", q_valid, q_data, ip);
        end
        // Find the DONE cycle of the 0000 prefetch (mem_req just fell) and pop there.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_req) hi = 1'b1;
            else if (hi) break;
        end
        total++; if (hi !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL wrap_done_seen got hi=%b req=%b want 1/0", hi, mem_req); end
        q_pop = 1'b1;
        @(negedge clk);
        q_pop = 1'b0; mem_ready = 1'b0;
        total++; if (q_valid !== 1'b1 || q_data !== 16'h5000 || ip !== 16'h0002) begin
            bad++; $display("FAIL pushpop got valid=%b data=%h ip=%h want 1/5000/0002", q_valid, q_data, ip);
        end
        @(negedge clk);
        q_pop = 1'b1;
        @(negedge clk);
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL pushpop_count got valid=%b want 0", q_valid); end
        @(negedge clk);
        q_pop = 1'b0;
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL empty_pop got valid=%b want 0", q_valid); end
        mem_ready = 1'b1;
        for (int c = 0; c < 10 && !q_valid; c++) @(negedge clk);
        total++; if (q_valid !== 1'b1 || q_data !== 16'h5002) begin
            bad++; $display("FAIL empty_pop_next got valid=%b data=%h want 1/5002", q_valid, q_data);
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        int ackc;
        found = 1'b0; ackc = 0;
        use_fixed = 1'b1; fixed_rdata = 16'h7777; mem_ready = 1'b1;
        data_req = 1'b1; data_wr = 1'b0; data_seg = 2'd3; data_m1 = 3'd3; data_m2 = 3'd5; data_desp = 16'h0004;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (mem_req && op) found = 1'b1;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rm_grant got=%b want=1", found); end
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        data_req = 1'b0;
        total++; if (mem_req !== 1'b0 || data_ack !== 1'b0 || ip !== 16'h0000 || q_valid !== 1'b0) begin
            bad++; $display("FAIL rm_reset got req=%b ack=%b ip=%h valid=%b want 0/0/0000/0", mem_req, data_ack, ip, q_valid);
        end
        rst_n = 1'b1; mem_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (data_ack) ackc++;
        end
        total++; if (ackc !== 0) begin bad++; $display("FAIL rm_no_ack got=%0d want=0", ackc); end
    endtask

    initial begin
        test_reset;
        test_prefetch_fill;
        test_data_read;
        test_data_write;
        test_flush;
        test_wrap_pushpop;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
